// File: rtl/spi_ioexp_sync.sv
// spi_ioexp_sync
//   SPI I/O expander core. Every signal is handled on clk. sclk, ce and sin are
//   oversampled through synchronisers and are never used as clocks.
//   A frame reads the expander inputs out on sout, LSB first. It also shifts
//   new expander output data in from sin, and the first bit received lands in
//   the MSB. The outputs are committed on ce rise only when the frame carried
//   exactly OUTBITS sample edges. Any other bit count sets the sticky frame_err.
//
// Ports
//   clk        system clock
//   reset      synchronous reset, active high
//   sclk       SPI clock (async, f_sclk <= f_clk/8)
//   ce         SPI chip enable, active low (async)
//   sin        SPI data into the expander
//   sout       SPI data out of the expander (0 outside a frame)
//   inputs     expander inputs (async)
//   outputs    expander outputs (registered)
//   irq        synced inputs differ from the snapshot taken at the last ce fall
//   frame_err  last frame had the wrong bit count (sticky until a good frame)
//
// FSM states
//   state     | meaning
//   WAIT_IDLE | after reset; waits for ce high so that a low ce is never a frame
//   IDLE      | no frame in progress; waits for a ce fall
//   ACTIVE    | frame in progress; sclk edges shift data until ce rises

module spi_ioexp_sync #(
  parameter int INBITS      = 3,
  parameter int OUTBITS     = 7,
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               ce,
  input  logic               sin,
  output logic               sout,
  input  logic [INBITS-1:0]  inputs,
  output logic [OUTBITS-1:0] outputs,
  output logic               irq,
  output logic               frame_err
);

  localparam int CW = $clog2(OUTBITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(OUTBITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(OUTBITS + 1);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;

  logic [SYNC_STAGES-1:0]             sclk_sync, ce_sync, sin_sync;
  logic [SYNC_STAGES-1:0][INBITS-1:0] in_sync;
  logic                               sclk_s, ce_s, sin_s;
  logic [INBITS-1:0]                  inputs_s;
  logic                               sclk_d, ce_d;

  // Edge pulses are registered one cycle after detection. sin travels with
  // them, so a sample pulse always pairs with the data that was present at
  // its edge. The extra stage also sets the ce-rise-to-commit latency.
  logic sample_p, launch_p, ce_fall_p, ce_rise_p, sin_p;

  logic [1:0]         state;
  logic [OUTBITS-1:0] shift_in;
  logic [INBITS-1:0]  shift_out;
  logic [INBITS-1:0]  snapshot;
  logic [CW-1:0]      bitcnt;
  logic               first_lead;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge;

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign ce_s     = ce_sync[SYNC_STAGES-1];
  assign sin_s    = sin_sync[SYNC_STAGES-1];
  assign inputs_s = in_sync[SYNC_STAGES-1];

  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sclk_fall  = ~sclk_s & sclk_d;
  assign lead_edge  = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge = CPOL ? sclk_rise : sclk_fall;

  assign sout = (state == ACTIVE) ? shift_out[0] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      ce_sync   <= '0;
      sin_sync  <= '0;
      in_sync   <= '0;
      sclk_d    <= 1'b0;
      ce_d      <= 1'b0;
      sample_p  <= 1'b0;
      launch_p  <= 1'b0;
      ce_fall_p <= 1'b0;
      ce_rise_p <= 1'b0;
      sin_p     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ce_sync   <= {ce_sync[SYNC_STAGES-2:0], ce};
      sin_sync  <= {sin_sync[SYNC_STAGES-2:0], sin};
      in_sync   <= {in_sync[SYNC_STAGES-2:0], inputs};
      sclk_d    <= sclk_s;
      ce_d      <= ce_s;
      sample_p  <= CPHA ? trail_edge : lead_edge;
      launch_p  <= CPHA ? lead_edge : trail_edge;
      ce_fall_p <= ce_d & ~ce_s;
      ce_rise_p <= ~ce_d & ce_s;
      sin_p     <= sin_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_IDLE;
      shift_in   <= '0;
      shift_out  <= '0;
      snapshot   <= '0;
      bitcnt     <= '0;
      first_lead <= 1'b0;
      outputs    <= '0;
      irq        <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // A ce fall below overrides this set, so a change that lands in the
      // same cycle goes into the new snapshot instead of raising irq.
      if ((state != WAIT_IDLE) && (inputs_s != snapshot))
        irq <= 1'b1;

      case (state)
        WAIT_IDLE: begin
          if (ce_s)
            state <= IDLE;
        end
        IDLE: begin
          if (ce_fall_p) begin
            state      <= ACTIVE;
            shift_out  <= inputs_s;
            snapshot   <= inputs_s;
            bitcnt     <= '0;
            irq        <= 1'b0;
            first_lead <= 1'b1;
          end
        end
        ACTIVE: begin
          // A ce rise takes priority over a sample edge that arrives in the
          // same cycle, and that edge is not counted.
          if (ce_rise_p) begin
            state <= IDLE;
            if (bitcnt == CNT_FULL) begin
              outputs   <= shift_in;
              frame_err <= 1'b0;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sample_p) begin
              shift_in <= {shift_in[OUTBITS-2:0], sin_p};
              if (bitcnt != CNT_SAT)
                bitcnt <= bitcnt + 1'b1;
            end
            if (launch_p) begin
              first_lead <= 1'b0;
              // With CPHA=1, bit 0 has been on sout since the ce fall, so
              // the first leading edge has nothing new to present.
              if (!(CPHA && first_lead))
                shift_out <= shift_out >> 1;
            end
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ioexp_sync.sv
// Testbench for spi_ioexp_sync. It drives an SPI master model and keeps a
// reference model of the expected outputs, frame_err, sout and irq.
module tb_spi_ioexp_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       b_sclk, b_ce, b_sin;
  logic       sel;
  logic [2:0] inputs;

  logic       sclk0, ce0, sclk1, ce1;
  logic       sout0, sout1, irq0, irq1, err0, err1;
  logic [6:0] out0, out1;

  assign sclk0 = (sel == 1'b0) ? b_sclk : 1'b0;
  assign ce0   = (sel == 1'b0) ? b_ce   : 1'b1;
  assign sclk1 = (sel == 1'b1) ? b_sclk : 1'b0;
  assign ce1   = (sel == 1'b1) ? b_ce   : 1'b1;

  spi_ioexp_sync #(.INBITS(3), .OUTBITS(7), .SYNC_STAGES(2), .CPOL(1'b0), .CPHA(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .sclk(sclk0), .ce(ce0), .sin(b_sin), .sout(sout0),
    .inputs(inputs), .outputs(out0), .irq(irq0), .frame_err(err0));

  spi_ioexp_sync #(.INBITS(3), .OUTBITS(7), .SYNC_STAGES(2), .CPOL(1'b0), .CPHA(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .sclk(sclk1), .ce(ce1), .sin(b_sin), .sout(sout1),
    .inputs(inputs), .outputs(out1), .irq(irq1), .frame_err(err1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state.
  logic [6:0] m_out;
  logic       m_err;
  logic       m_act;
  logic [2:0] m_snap, m_in, m_fr_in;
  logic       m_irq;
  logic       m_q[$];
  int         m_pos;

  logic       mon_en = 1'b0;
  logic [7:0] prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every change of {frame_err, outputs} on DUT0 must match the
  // next expected commit, both in value and in cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [7:0] cur;
      exp_t       e;
      cur = {err0, out0};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_commit: got %0h expected no change (t=%0t)", cur, $time);
        end else begin
          e = exp_q.pop_front();
          check("commit_value", 32'(cur), 32'(e.val));
          check("commit_cycle", cyc, e.cyc);
        end
        prev = cur;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] to_bits(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[n-1-i];
    return r;
  endfunction

  task automatic set_inputs(input logic [2:0] v);
    inputs = v;
    m_in   = v;
  endtask

  task automatic check_irq();
    logic e;
    e = m_irq | (m_in != m_snap);
    m_irq = e;
    check("irq", 32'(irq0), 32'(e));
  endtask

  task automatic push_if_changed(input logic [6:0] n_out, input logic n_err, input int at);
    exp_t e;
    if ({n_err, n_out} != {m_err, m_out}) begin
      e.val = {n_err, n_out};
      e.cyc = at;
      exp_q.push_back(e);
    end
    m_out = n_out;
    m_err = n_err;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    if (mon_en) push_if_changed(7'h00, 1'b0, cyc + 1);
    m_out = '0; m_err = 1'b0; m_act = 1'b0; m_snap = '0; m_irq = 1'b0;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic ce_fall();
    b_ce    = 1'b0;
    m_act   = 1'b1;
    m_fr_in = m_in;
    m_pos   = 0;
    m_q.delete();
    if (sel == 1'b0) begin
      m_snap = m_in;
      m_irq  = 1'b0;
    end
    tick(8);
    if (sel == 1'b0) check_irq();
  endtask

  task automatic send_bits(input int n, input logic [15:0] bits);
    logic act, exp_b;
    for (int i = 0; i < n; i++) begin
      if (sel == 1'b0) begin
        b_sin = bits[i]; b_sclk = 1'b1;
        tick(4);
        act = sout0;
        b_sclk = 1'b0;
        tick(4);
      end else begin
        b_sin = bits[i];
        tick(4);
        act = sout1;
        b_sclk = 1'b1;
        tick(4);
        b_sclk = 1'b0;
      end
      exp_b = (m_act && m_pos < 3) ? m_fr_in[m_pos[1:0]] : 1'b0;
      check("sout", 32'(act), 32'(exp_b));
      if (m_act) m_q.push_back(bits[i]);
      m_pos++;
    end
    if (sel == 1'b1) tick(4);
  endtask

  task automatic ce_rise();
    logic [6:0] n_out;
    b_ce = 1'b1;
    if (sel == 1'b0 && m_act) begin
      if (m_q.size() == 7) begin
        n_out = '0;
        for (int k = 0; k < 7; k++) n_out[6-k] = m_q[k];
        push_if_changed(n_out, 1'b0, cyc + 4);
      end else begin
        push_if_changed(m_out, 1'b1, cyc + 4);
      end
    end
    m_act = 1'b0;
    tick(8);
    if (sel == 1'b0) check_irq();
  endtask

  task automatic frame(input int n, input logic [15:0] val);
    tick(6);
    ce_fall();
    send_bits(n, to_bits(val, n));
    ce_rise();
  endtask

  initial begin
    logic [15:0] v;
    int          n;

    // 1: reset held for 2 clk with ce high
    sel = 1'b0; b_sclk = 1'b0; b_ce = 1'b1; b_sin = 1'b0;
    set_inputs(3'b000);
    m_out = '0; m_err = 1'b0; m_act = 1'b0; m_snap = '0; m_irq = 1'b0; m_pos = 0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_outputs", 32'(out0), 32'h0);
    check("rst_sout", 32'(sout0), 32'h0);
    check("rst_irq", 32'(irq0), 32'h0);
    check("rst_frame_err", 32'(err0), 32'h0);
    check("rst_outputs_cpha0", 32'(out1), 32'h0);
    tick(6);
    prev   = {err0, out0};
    mon_en = 1'b1;

    // 2: basic 7-bit frame
    set_inputs(3'b101);
    frame(7, 16'b1011001);

    // 3: short and long frames are rejected, then a good frame recovers
    frame(5, 16'h15);
    frame(9, 16'h1A5);
    check("hold_outputs", 32'(out0), 32'b1011001);
    check("err_sticky", 32'(err0), 32'h1);
    frame(7, 16'h7F);
    check("err_cleared", 32'(err0), 32'h0);

    // 4: input-change interrupt
    set_inputs(3'b111);
    tick(3);
    check("irq_rise", 32'(irq0), 32'h1);
    m_irq = 1'b1;
    ce_fall();
    check("irq_clear", 32'(irq0), 32'h0);
    check("sout_bit0", 32'(sout0), 32'h1);
    send_bits(7, to_bits(16'h2A, 7));
    ce_rise();

    // 5: reset in the middle of a frame discards it
    tick(6);
    ce_fall();
    send_bits(3, to_bits(16'h5, 3));
    do_reset(1);
    send_bits(4, to_bits(16'hC, 4));
    ce_rise();
    check("rst_mid_outputs", 32'(out0), 32'h0);
    check("rst_mid_err", 32'(err0), 32'h0);
    frame(7, 16'h33);

    // 6: CPHA=0 instance
    sel = 1'b1;
    set_inputs(3'($urandom_range(0, 7)));
    frame(7, 16'h55);
    check("cpha0_outputs", 32'(out1), 32'h55);
    check("cpha0_err", 32'(err1), 32'h0);
    sel = 1'b0;
    tick(4);

    // Randomised frames on the CPHA=1 instance
    for (int r = 0; r < 16; r++) begin
      n = $urandom_range(5, 9);
      v = 16'($urandom_range(0, 16'hFFFF));
      set_inputs(3'($urandom_range(0, 7)));
      tick(6);
      ce_fall();
      send_bits(n, to_bits(v, n));
      if ($urandom_range(0, 3) == 0) begin
        set_inputs(3'($urandom_range(0, 7)));
        tick(4);
      end
      ce_rise();
    end

    tick(10);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
